// File: rtl/nibble_feed_pkg.sv
// rtl/nibble_feed_pkg.sv - shared constants and types for the nibble feed serializer
// Purpose: beat geometry (NIBBLE_W x BEATS = WORD_W), beat counter type and
//          serializer state encoding used by the top level.
// Ports:   none (package)
package nibble_feed_pkg;

   localparam int NIBBLE_W = 4;
   localparam int BEATS    = 4;
   localparam int WORD_W   = NIBBLE_W * BEATS;

   typedef logic [1:0] beat_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage

// File: rtl/nibble_feed_fifo.sv
// rtl/nibble_feed_fifo.sv - synchronous word FIFO feeding the serializer
// Purpose: DEPTH-entry FIFO with registered occupancy count.
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   i_push/i_push_data - write request and word (ignored when full)
//   i_pop            - read request (ignored when empty)
//   o_pop_data       - head word, valid whenever o_empty is low
//   o_full/o_empty   - decoded from the count register
//   o_count          - number of stored words, 0..DEPTH
module nibble_feed_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_push_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_pop_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full     = (r_count == CW'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_pop_data = r_mem[r_rd_ptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: pointer reset alone discards stale contents.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/nibble_feed_serializer.sv
// rtl/nibble_feed_serializer.sv - buffers 16-bit words and emits them as LSB-first nibbles
// Purpose: FIFO + shift-register serializer with a last-beat marker.
// Ports:
//   clk, reset                 - system clock, synchronous active-high reset
//   io_in_valid/ready/bits     - upstream word stream (ready from count only)
//   io_out_valid/ready/bits    - nibble stream, register driven
//   io_out_last                - final nibble of a word
//   io_count                   - FIFO occupancy, excludes the word being shifted
module nibble_feed_serializer #(
   parameter int DEPTH    = 4,
   parameter int WORD_W   = nibble_feed_pkg::WORD_W,
   parameter int NIBBLE_W = nibble_feed_pkg::NIBBLE_W,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                io_in_valid,
   output logic                io_in_ready,
   input  logic [WORD_W-1:0]   io_in_bits,
   output logic                io_out_valid,
   input  logic                io_out_ready,
   output logic [NIBBLE_W-1:0] io_out_bits,
   output logic                io_out_last,
   output logic [CW-1:0]       io_count
);

   import nibble_feed_pkg::*;

   localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);
   localparam beat_t PRE_LAST  = beat_t'(BEATS - 2);

   ser_state_t        r_state;
   logic [WORD_W-1:0] r_shift;
   beat_t             r_beat;
   logic              r_last;

   logic [WORD_W-1:0] w_fifo_data;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CW-1:0]     w_fifo_count;
   logic              w_push;
   logic              w_out_fire;
   logic              w_word_done;
   logic              w_load;

   assign io_in_ready = !w_fifo_full;
   assign w_push      = io_in_valid && io_in_ready;

   assign w_out_fire  = (r_state == SHIFT) && io_out_ready;
   assign w_word_done = w_out_fire && (r_beat == LAST_BEAT);
   // Reload straight from the FIFO on the final beat so words stream without a bubble.
   assign w_load      = !w_fifo_empty && ((r_state == IDLE) || w_word_done);

   nibble_feed_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (io_in_bits),
      .i_pop       (w_load),
      .o_pop_data  (w_fifo_data),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   // Leaving SHIFT clears the shift register and beat so idle outputs read zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_beat  <= '0;
         r_last  <= 1'b0;
      end else if (w_load) begin
         r_state <= SHIFT;
         r_shift <= w_fifo_data;
         r_beat  <= '0;
         r_last  <= 1'b0;
      end else if (w_word_done) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_beat  <= '0;
         r_last  <= 1'b0;
      end else if (w_out_fire) begin
         r_shift <= r_shift >> NIBBLE_W;
         r_beat  <= r_beat + 1'b1;
         r_last  <= (r_beat == PRE_LAST);
      end
   end

   assign io_out_valid = (r_state == SHIFT);
   assign io_out_bits  = r_shift[NIBBLE_W-1:0];
   assign io_out_last  = r_last;
   assign io_count     = w_fifo_count;

endmodule
